// File: rtl/clint_responder_pkg.sv
// Shared definitions for the core-local interruptor: register offsets,
// RTC divider constant and the request/response bundles.
package clint_responder_pkg;

    localparam int unsigned clk_divider_rtc = 49;

    localparam logic [31:0] clint_msip_off        = 32'h0000_0000;
    localparam logic [31:0] clint_mtimecmp_lo_off = 32'h0000_4000;
    localparam logic [31:0] clint_mtimecmp_hi_off = 32'h0000_4004;
    localparam logic [31:0] clint_mtime_lo_off    = 32'h0000_BFF8;
    localparam logic [31:0] clint_mtime_hi_off    = 32'h0000_BFFC;

    typedef struct packed {
        logic        valid;
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } clint_in_type;

    typedef struct packed {
        logic [31:0] rdata;
        logic        ready;
    } clint_out_type;

    // Lanes selected by lane_mask take wdata, the rest keep old_word.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] wdata,
                                                input logic [31:0] lane_mask);
        return (old_word & ~lane_mask) | (wdata & lane_mask);
    endfunction

endpackage

// File: rtl/clint_responder_if.sv
// Data-memory request/response channel between the core and the CLINT.
interface clint_if;
    logic        clint_valid;
    logic        clint_instr;
    logic [31:0] clint_addr;
    logic [31:0] clint_wdata;
    logic [3:0]  clint_wstrb;
    logic [31:0] clint_rdata;
    logic        clint_ready;

    modport master (
        output clint_valid, clint_instr, clint_addr, clint_wdata, clint_wstrb,
        input  clint_rdata, clint_ready
    );

    modport slave (
        input  clint_valid, clint_instr, clint_addr, clint_wdata, clint_wstrb,
        output clint_rdata, clint_ready
    );
endinterface

// File: rtl/clint_responder_rtc_tick_gen.sv
// RTC divider: a counter wrapping at rtc_div toggles a phase bit; the
// cycle in which the phase is about to rise is reported as a one-cycle tick.
module rtc_tick_gen
    import clint_responder_pkg::*;
#(
    parameter int unsigned rtc_div = clk_divider_rtc
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);
    localparam int unsigned cw = (rtc_div > 0) ? $clog2(rtc_div + 1) : 1;
    localparam logic [cw-1:0] div_last = cw'(rtc_div);

    logic [cw-1:0] count_reg;
    logic          phase_reg;
    logic          wrap;

    assign wrap = (count_reg == div_last);
    assign tick = wrap && !phase_reg;

    always_ff @(posedge clock) begin
        if (!reset) begin
            count_reg <= '0;
            phase_reg <= 1'b0;
        end else if (wrap) begin
            count_reg <= '0;
            phase_reg <= ~phase_reg;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end
endmodule

// File: rtl/clint_responder.sv
// Single-hart CLINT: msip, mtimecmp and a free-running mtime behind a
// one-cycle request/response port, driving the software/timer interrupts.
module clint_responder
    import clint_responder_pkg::*;
#(
    parameter int unsigned rtc_div   = clk_divider_rtc,
    parameter logic [31:0] addr_mask = 32'h0000_FFFF
) (
    input  logic   clock,
    input  logic   reset,
    clint_if.slave bus,
    output logic   clint_msip,
    output logic   clint_mtip
);
    clint_in_type  req;
    clint_out_type resp_reg, resp_next;
    logic [31:0]   word_off, lane_mask, read_word;
    logic          is_write, tick;
    logic          msip_reg, msip_next, msip_out_reg, mtip_reg;
    logic [63:0]   mtimecmp_reg, mtimecmp_next;
    logic [63:0]   mtime_reg, mtime_next, mtime_inc;

    assign req.valid = bus.clint_valid;
    assign req.instr = bus.clint_instr;
    assign req.addr  = bus.clint_addr;
    assign req.wdata = bus.clint_wdata;
    assign req.wstrb = bus.clint_wstrb;

    assign bus.clint_rdata = resp_reg.rdata;
    assign bus.clint_ready = resp_reg.ready;
    assign clint_msip      = msip_out_reg;
    assign clint_mtip      = mtip_reg;

    assign word_off = req.addr & addr_mask & 32'hFFFF_FFFC;
    assign is_write = req.valid && !req.instr && (req.wstrb != 4'b0000);

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane_mask[gi*8 +: 8] = {8{req.wstrb[gi]}};
    end

    rtc_tick_gen #(.rtc_div(rtc_div)) u_rtc (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

    always_comb begin
        read_word = '0;
        case (word_off)
            clint_msip_off:        read_word = {31'd0, msip_reg};
            clint_mtimecmp_lo_off: read_word = mtimecmp_reg[31:0];
            clint_mtimecmp_hi_off: read_word = mtimecmp_reg[63:32];
            clint_mtime_lo_off:    read_word = mtime_reg[31:0];
            clint_mtime_hi_off:    read_word = mtime_reg[63:32];
            default:               read_word = '0;
        endcase
    end

    // Fetches are acknowledged with zero data and never touch state.
    always_comb begin
        resp_next.ready = req.valid;
        resp_next.rdata = (req.valid && !req.instr) ? read_word : '0;
    end

    // A written mtime half overrides the tick increment for that half only;
    // the other half still follows mtime+1, so a lo->hi carry survives.
    always_comb begin
        msip_next     = msip_reg;
        mtimecmp_next = mtimecmp_reg;
        mtime_inc     = mtime_reg + 64'd1;
        mtime_next    = tick ? mtime_inc : mtime_reg;
        if (is_write) begin
            case (word_off)
                clint_msip_off:
                    msip_next = req.wstrb[0] ? req.wdata[0] : msip_reg;
                clint_mtimecmp_lo_off:
                    mtimecmp_next[31:0] = merge_lanes(mtimecmp_reg[31:0], req.wdata, lane_mask);
                clint_mtimecmp_hi_off:
                    mtimecmp_next[63:32] = merge_lanes(mtimecmp_reg[63:32], req.wdata, lane_mask);
                clint_mtime_lo_off:
                    mtime_next[31:0] = merge_lanes(mtime_reg[31:0], req.wdata, lane_mask);
                clint_mtime_hi_off:
                    mtime_next[63:32] = merge_lanes(mtime_reg[63:32], req.wdata, lane_mask);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            resp_reg     <= '0;
            msip_reg     <= 1'b0;
            msip_out_reg <= 1'b0;
            mtip_reg     <= 1'b0;
            mtimecmp_reg <= '1;
            mtime_reg    <= '0;
        end else begin
            resp_reg     <= resp_next;
            msip_reg     <= msip_next;
            msip_out_reg <= msip_reg;
            mtip_reg     <= (mtime_reg >= mtimecmp_reg);
            mtimecmp_reg <= mtimecmp_next;
            mtime_reg    <= mtime_next;
        end
    end
endmodule
